crd_intersect: RTL and testbench
================================

// Module: crd_intersect
// PURPOSE
//  Two-way sparse coordinate intersecter (joiner, AND mode). Consumes two
//  aligned (coordinate, position) fiber streams and emits only the coordinates
//  present in both, with the matching position from each side. Sits directly
//  upstream of crddrop: its coord_out feeds crddrop's outer coord input.
//  Stream words are 17 bits: [16]=0 data, [15:0] value;
//  [16]=1 token: stop S_n = 17'h10000+n (n<=255), done = 17'h10100.
// PARAMETERS
//  DATA_WIDTH  16  payload width; stream word is DATA_WIDTH+1 bits
// PORTS
//  clk               in   1   clock
//  rst_n             in   1   async active-low reset
//  clk_en            in   1   0 = hold all state, no handshakes complete
//  flush             in   1   sync clear of state/output reg (same values as reset)
//  tile_en           in   1   0 = all readies and valids forced 0
//  coord_in_0        in   17  stream A coordinate
//  pos_in_0          in   17  stream A position (aligned with coord_in_0)
//  coord_in_0_valid  in   1   A word valid (coord and pos together)
//  coord_in_0_ready  out  1   A pop (consumes coord and pos)
//  coord_in_1, pos_in_1, coord_in_1_valid, coord_in_1_ready: same for stream B
//  coord_out         out  17  intersected coordinate / token
//  coord_out_valid   out  1   output bundle valid
//  coord_out_ready   in   1
//  pos_out_0         out  17  A position of matched coord / token
//  pos_out_0_valid   out  1   == coord_out_valid
//  pos_out_0_ready   in   1
//  pos_out_1, pos_out_1_valid, pos_out_1_ready: same for stream B
//  proto_err         out  1   sticky: mismatched tokens seen
// BEHAVIOUR
//  - Reset/flush: all outputs 0, output register empty, proto_err 0.
//  - One-entry output register holds {coord, pos0, pos1}; all three valids
//    assert together. Bundle fires only when all three readies are 1 in the
//    same cycle. Valid is never dropped and data is never changed until fire.
//  - slot_free = reg empty | bundle fires this cycle (full throughput).
//  - Decision made when both input valids are 1 and slot_free (else no pop):
//    * both data, cA==cB: load {cA,pA,pB}, pop A and B.
//    * both data, cA<cB: pop A only, no load. cA>cB: pop B only.
//    * data vs token: pop the data side only (drain to the stop).
//    * both stop, equal level: load {S_n,S_n,S_n}, pop both.
//    * both done: load {done,done,done}, pop both; next word starts next tile.
//    * token mismatch (diff stop levels, or stop vs done): set proto_err,
//      pop the side whose token has lower value; no load.
//  - Latency: matched input pair visible on outputs the cycle after the pop.
//  - Data comparison unsigned on [15:0]; data-vs-data ties only as above.
//  - Readies are combinational from valids/state/output readies; no
//    combinational path from input data to input valid.
//  - clk_en=0: registers hold, readies and any fire suppressed.
//  - tile_en=0: readies/valids 0; registers hold.
//  - Async reset mid-bundle discards it; flush asserted with a fire: flush wins.
// TESTING
//  - A=[1,3,5,S0,D], B=[3,4,5,S0,D], pos=index, all ready -> out
//    coord=[3,5,S0,D], pos0=[1,2,S0,D], pos1=[0,2,S0,D].
//  - A=[2,S0,7,S1,D], B=[S0,7,8,S1,D] -> coord=[S0,7,S1,D]; A's 2 dropped.
//  - Disjoint A=[1,2,S0,D], B=[3,S0,D] -> coord=[S0,D] only.
//  - Hold pos_out_1_ready=0 for 5 cycles mid-stream -> no fire, output words
//    stable, no input pops while reg full; resume yields identical stream.
//  - Random valid/ready gaps, 2 back-to-back tiles -> output equals golden
//    per tile, done emitted exactly twice, throughput 1/cycle when unstalled.
//  - A=[S0,D], B=[S1,D] -> proto_err=1, then D,D pair emits done.

Source files
------------

// File: rtl/crd_intersect_if.sv
// Stream bundle for crd_intersect: two aligned (coord, pos) input fibers and
// the intersected {coord, pos0, pos1} output bundle.
interface crd_intersect_if #(parameter int DATA_WIDTH = 16);
    localparam int W = DATA_WIDTH + 1;

    logic [W-1:0] coord_in_0;
    logic [W-1:0] pos_in_0;
    logic         coord_in_0_valid;
    logic         coord_in_0_ready;
    logic [W-1:0] coord_in_1;
    logic [W-1:0] pos_in_1;
    logic         coord_in_1_valid;
    logic         coord_in_1_ready;

    logic [W-1:0] coord_out;
    logic         coord_out_valid;
    logic         coord_out_ready;
    logic [W-1:0] pos_out_0;
    logic         pos_out_0_valid;
    logic         pos_out_0_ready;
    logic [W-1:0] pos_out_1;
    logic         pos_out_1_valid;
    logic         pos_out_1_ready;

    modport master (
        output coord_in_0, pos_in_0, coord_in_0_valid,
        output coord_in_1, pos_in_1, coord_in_1_valid,
        input  coord_in_0_ready, coord_in_1_ready,
        input  coord_out, coord_out_valid, pos_out_0, pos_out_0_valid,
        input  pos_out_1, pos_out_1_valid,
        output coord_out_ready, pos_out_0_ready, pos_out_1_ready
    );

    modport slave (
        input  coord_in_0, pos_in_0, coord_in_0_valid,
        input  coord_in_1, pos_in_1, coord_in_1_valid,
        output coord_in_0_ready, coord_in_1_ready,
        output coord_out, coord_out_valid, pos_out_0, pos_out_0_valid,
        output pos_out_1, pos_out_1_valid,
        input  coord_out_ready, pos_out_0_ready, pos_out_1_ready
    );
endinterface

// File: rtl/crd_intersect.sv
// Two-way sparse coordinate intersecter: pops the smaller coordinate, emits
// {coord, posA, posB} for coordinates present in both fibers.
module crd_intersect #(
    parameter int DATA_WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic             flush,
    input  logic             tile_en,
    crd_intersect_if.slave   bus,
    output logic             proto_err
);
    localparam int W = DATA_WIDTH + 1;

    logic         active;
    logic         fire;
    logic         slot_free;
    logic         decide;
    logic         a_tok;
    logic         b_tok;
    logic         a_lt_b;
    logic         words_eq;
    logic         sel_a;
    logic         sel_b;
    logic         sel_load;
    logic         sel_mismatch;
    logic         do_load;

    logic         out_full;
    logic [W-1:0] out_coord;
    logic [W-1:0] out_pos0;
    logic [W-1:0] out_pos1;

    assign active    = clk_en & tile_en;
    assign fire      = active & out_full & bus.coord_out_ready
                     & bus.pos_out_0_ready & bus.pos_out_1_ready;
    assign slot_free = ~out_full | fire;
    assign decide    = active & bus.coord_in_0_valid & bus.coord_in_1_valid & slot_free;

    // Payload compare orders data by value and tokens by level (stop < done).
    assign a_tok    = bus.coord_in_0[W-1];
    assign b_tok    = bus.coord_in_1[W-1];
    assign a_lt_b   = bus.coord_in_0[W-2:0] < bus.coord_in_1[W-2:0];
    assign words_eq = bus.coord_in_0 == bus.coord_in_1;

    // NOTE: every output of a combinational block gets a default first so
    // no path through the case can infer a latch.
    always_comb begin
        sel_a        = 1'b0;
        sel_b        = 1'b0;
        sel_load     = 1'b0;
        sel_mismatch = 1'b0;
        unique case ({a_tok, b_tok})
            2'b00: begin
                if (words_eq) begin
                    sel_a    = 1'b1;
                    sel_b    = 1'b1;
                    sel_load = 1'b1;
                end else if (a_lt_b) begin
                    sel_a = 1'b1;
                end else begin
                    sel_b = 1'b1;
                end
            end
            2'b01:   sel_a = 1'b1;
            2'b10:   sel_b = 1'b1;
            default: begin
                if (words_eq) begin
                    sel_a    = 1'b1;
                    sel_b    = 1'b1;
                    sel_load = 1'b1;
                end else begin
                    sel_mismatch = 1'b1;
                    if (a_lt_b) sel_a = 1'b1;
                    else        sel_b = 1'b1;
                end
            end
        endcase
    end

    assign do_load              = decide & sel_load;
    assign bus.coord_in_0_ready = decide & sel_a;
    assign bus.coord_in_1_ready = decide & sel_b;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_full  <= 1'b0;
            out_coord <= '0;
            out_pos0  <= '0;
            out_pos1  <= '0;
            proto_err <= 1'b0;
        end else if (flush) begin
            out_full  <= 1'b0;
            out_coord <= '0;
            out_pos0  <= '0;
            out_pos1  <= '0;
            proto_err <= 1'b0;
        end else begin
            if (do_load) begin
                out_full  <= 1'b1;
                out_coord <= bus.coord_in_0;
                out_pos0  <= a_tok ? bus.coord_in_0 : bus.pos_in_0;
                out_pos1  <= b_tok ? bus.coord_in_1 : bus.pos_in_1;
            end else if (fire) begin
                out_full <= 1'b0;
            end
            if (decide && sel_mismatch) proto_err <= 1'b1;
        end
    end

    assign bus.coord_out       = out_coord;
    assign bus.pos_out_0       = out_pos0;
    assign bus.pos_out_1       = out_pos1;
    assign bus.coord_out_valid = out_full & tile_en;
    assign bus.pos_out_0_valid = out_full & tile_en;
    assign bus.pos_out_1_valid = out_full & tile_en;
endmodule

// File: tb/tb_crd_intersect.sv
// Scoreboard bench for crd_intersect: randomized fibers, set-intersection
// reference model, decoupled output monitor.
`timescale 1ns/1ps
module tb_crd_intersect;
    localparam logic [16:0] DONE = 17'h10100;

    typedef struct packed { logic [16:0] c; logic [16:0] p; } word_t;
    typedef struct packed { logic [16:0] c; logic [16:0] p0; logic [16:0] p1; } out_t;

    logic clk, rst_n, clk_en, flush, tile_en, proto_err;
    crd_intersect_if #(.DATA_WIDTH(16)) bus ();

    crd_intersect #(.DATA_WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_en    (clk_en),
        .flush     (flush),
        .tile_en   (tile_en),
        .bus       (bus.slave),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    word_t qa[$], qb[$], ta[$], tbq[$];
    out_t  exp_q[$];
    int    fire_cycles[$];
    int    n_tests = 0, n_fail = 0;
    int    in_gap_pct = 0, out_gap_pct = 0;
    int    fire_count = 0, done_cnt = 0;
    bit    hold1 = 1'b0;
    bit    a_take = 1'b0, b_take = 1'b0;
    bit    pend = 1'b0;
    out_t  prev_out;

    function automatic logic [16:0] stop_tok(input int n);
        return 17'h10000 + 17'(n);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input bit side, input logic [16:0] c, input logic [16:0] p);
        word_t w;
        w.c = c;
        w.p = p;
        if (side) tbq.push_back(w);
        else      ta.push_back(w);
    endfunction

    // Reference: split both fibers at tokens; per segment emit the set
    // intersection in ascending order, then the shared token.
    function automatic void golden();
        int ia, ib, ea, eb;
        out_t o;
        ia = 0;
        ib = 0;
        while (ia < ta.size() && ib < tbq.size()) begin
            ea = ia;
            eb = ib;
            while (ea < ta.size() && !ta[ea].c[16]) ea++;
            while (eb < tbq.size() && !tbq[eb].c[16]) eb++;
            for (int i = ia; i < ea; i++)
                for (int j = ib; j < eb; j++)
                    if (ta[i].c == tbq[j].c) begin
                        o = {ta[i].c, ta[i].p, tbq[j].p};
                        exp_q.push_back(o);
                    end
            if (ea < ta.size() && eb < tbq.size()) begin
                o = {ta[ea].c, ta[ea].c, ta[ea].c};
                exp_q.push_back(o);
            end
            ia = ea + 1;
            ib = eb + 1;
        end
    endfunction

    function automatic void launch(input bit use_model);
        if (use_model) golden();
        foreach (ta[i])  qa.push_back(ta[i]);
        foreach (tbq[i]) qb.push_back(tbq[i]);
        ta.delete();
        tbq.delete();
    endfunction

    task automatic gen_tile();
        int nf;
        logic [15:0] ma, mb;
        logic [16:0] tok;
        nf = $urandom_range(1, 3);
        for (int f = 0; f < nf; f++) begin
            ma = 16'($urandom);
            mb = 16'($urandom);
            for (int c = 0; c < 16; c++) begin
                if (ma[c]) add(1'b0, {1'b0, 16'(c * 4001)}, {1'b0, 16'($urandom)});
                if (mb[c]) add(1'b1, {1'b0, 16'(c * 4001)}, {1'b0, 16'($urandom)});
            end
            tok = (f == nf - 1) ? stop_tok(1) : stop_tok(0);
            add(1'b0, tok, tok);
            add(1'b1, tok, tok);
        end
        add(1'b0, DONE, DONE);
        add(1'b1, DONE, DONE);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((qa.size() + qb.size() + exp_q.size()) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain"}, 64'(qa.size() + qb.size() + exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    // Input handshakes are resolved mid-cycle, applied after the next edge.
    initial forever begin
        @(negedge clk);
        a_take = bus.coord_in_0_valid & bus.coord_in_0_ready;
        b_take = bus.coord_in_1_valid & bus.coord_in_1_ready;
    end

    initial begin
        bus.coord_in_0_valid = 1'b0;
        bus.coord_in_0 = '0;
        bus.pos_in_0 = '0;
        forever begin
            @(posedge clk); #1;
            if (a_take) begin
                qa.delete(0);
                bus.coord_in_0_valid = 1'b0;
            end
            if (!bus.coord_in_0_valid && qa.size() > 0 && $urandom_range(99) >= in_gap_pct) begin
                bus.coord_in_0 = qa[0].c;
                bus.pos_in_0 = qa[0].p;
                bus.coord_in_0_valid = 1'b1;
            end
        end
    end

    initial begin
        bus.coord_in_1_valid = 1'b0;
        bus.coord_in_1 = '0;
        bus.pos_in_1 = '0;
        forever begin
            @(posedge clk); #1;
            if (b_take) begin
                qb.delete(0);
                bus.coord_in_1_valid = 1'b0;
            end
            if (!bus.coord_in_1_valid && qb.size() > 0 && $urandom_range(99) >= in_gap_pct) begin
                bus.coord_in_1 = qb[0].c;
                bus.pos_in_1 = qb[0].p;
                bus.coord_in_1_valid = 1'b1;
            end
        end
    end

    initial begin
        bus.coord_out_ready = 1'b0;
        bus.pos_out_0_ready = 1'b0;
        bus.pos_out_1_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.coord_out_ready = $urandom_range(99) >= out_gap_pct;
            bus.pos_out_0_ready = $urandom_range(99) >= out_gap_pct;
            bus.pos_out_1_ready = !hold1 && ($urandom_range(99) >= out_gap_pct);
        end
    end

    // Monitor: bundle stability while pending, valid alignment, scoreboard.
    initial forever begin
        out_t cur, exp;
        bit   fire_now;
        @(negedge clk);
        cur = {bus.coord_out, bus.pos_out_0, bus.pos_out_1};
        if (pend && tile_en) begin
            check("pending_valid_held", 64'(bus.coord_out_valid), 64'd1);
            check("pending_data_held", 64'(cur), 64'(prev_out));
        end
        if (bus.coord_out_valid | bus.pos_out_0_valid | bus.pos_out_1_valid)
            check("valid_alignment",
                  {61'd0, bus.coord_out_valid, bus.pos_out_0_valid, bus.pos_out_1_valid}, 64'd7);
        fire_now = rst_n && clk_en && !flush && bus.coord_out_valid && bus.coord_out_ready
                   && bus.pos_out_0_ready && bus.pos_out_1_ready;
        if (fire_now) begin
            fire_count++;
            fire_cycles.push_back(cyc);
            if (cur.c == DONE) done_cnt++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got %h expected none", cur);
            end else begin
                exp = exp_q.pop_front();
                check("out_bundle", 64'(cur), 64'(exp));
            end
        end
        pend = rst_n && !flush && bus.coord_out_valid && !fire_now;
        prev_out = cur;
    end

    initial begin
        int base, n, d0;
        out_t snap;
        rst_n = 1'b0;
        clk_en = 1'b1;
        flush = 1'b0;
        tile_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(bus.coord_out_valid), 64'd0);
        check("rst_coord", 64'(bus.coord_out), 64'd0);
        check("rst_pos0", 64'(bus.pos_out_0), 64'd0);
        check("rst_pos1", 64'(bus.pos_out_1), 64'd0);
        check("rst_proto_err", 64'(proto_err), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Basic intersection with positions = index; expectations written out.
        add(0, 17'd1, 17'd0); add(0, 17'd3, 17'd1); add(0, 17'd5, 17'd2);
        add(0, stop_tok(0), stop_tok(0)); add(0, DONE, DONE);
        add(1, 17'd3, 17'd0); add(1, 17'd4, 17'd1); add(1, 17'd5, 17'd2);
        add(1, stop_tok(0), stop_tok(0)); add(1, DONE, DONE);
        exp_q.push_back({17'd3, 17'd1, 17'd0});
        exp_q.push_back({17'd5, 17'd2, 17'd2});
        exp_q.push_back({stop_tok(0), stop_tok(0), stop_tok(0)});
        exp_q.push_back({DONE, DONE, DONE});
        launch(1'b0);
        wait_drain("basic", 200);

        // Data before a stop on one side is drained.
        add(0, 17'd2, 17'd0); add(0, stop_tok(0), stop_tok(0)); add(0, 17'd7, 17'd2);
        add(0, stop_tok(1), stop_tok(1)); add(0, DONE, DONE);
        add(1, stop_tok(0), stop_tok(0)); add(1, 17'd7, 17'd1); add(1, 17'd8, 17'd2);
        add(1, stop_tok(1), stop_tok(1)); add(1, DONE, DONE);
        launch(1'b1);
        wait_drain("drain_to_stop", 200);

        // Disjoint fibers: only tokens come out.
        add(0, 17'd1, 17'd0); add(0, 17'd2, 17'd1);
        add(0, stop_tok(0), stop_tok(0)); add(0, DONE, DONE);
        add(1, 17'd3, 17'd0); add(1, stop_tok(0), stop_tok(0)); add(1, DONE, DONE);
        launch(1'b1);
        wait_drain("disjoint", 200);

        // Output stall on pos_out_1 mid-stream.
        base = fire_count;
        add(0, 17'd1, 17'd0); add(0, 17'd3, 17'd1); add(0, 17'd5, 17'd2);
        add(0, stop_tok(0), stop_tok(0)); add(0, DONE, DONE);
        add(1, 17'd3, 17'd0); add(1, 17'd4, 17'd1); add(1, 17'd5, 17'd2);
        add(1, stop_tok(0), stop_tok(0)); add(1, DONE, DONE);
        launch(1'b1);
        n = 0;
        while (fire_count == base && n < 100) begin @(negedge clk); n++; end
        hold1 = 1'b1;
        n = 0;
        while (!(bus.coord_out_valid && !bus.pos_out_1_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        snap = {bus.coord_out, bus.pos_out_0, bus.pos_out_1};
        check("stall_reached", 64'(bus.coord_out_valid && !bus.pos_out_1_ready), 64'd1);
        repeat (5) begin
            check("stall_valid", 64'(bus.coord_out_valid), 64'd1);
            check("stall_data", 64'({bus.coord_out, bus.pos_out_0, bus.pos_out_1}), 64'(snap));
            check("stall_no_pop", {62'd0, bus.coord_in_0_ready, bus.coord_in_1_ready}, 64'd0);
            @(negedge clk);
        end
        hold1 = 1'b0;
        wait_drain("stall", 200);

        // Unstalled throughput: one bundle per cycle.
        for (int i = 0; i < 10; i++) begin
            add(0, 17'(i), 17'(i));
            add(1, 17'(i), 17'(i + 100));
        end
        add(0, stop_tok(0), stop_tok(0)); add(0, DONE, DONE);
        add(1, stop_tok(0), stop_tok(0)); add(1, DONE, DONE);
        fire_cycles.delete();
        launch(1'b1);
        wait_drain("throughput", 200);
        check("tput_count", 64'(fire_cycles.size()), 64'd12);
        if (fire_cycles.size() > 0)
            check("tput_span", 64'(fire_cycles[fire_cycles.size() - 1] - fire_cycles[0]), 64'd11);

        // Random gaps, two back-to-back tiles per round.
        in_gap_pct = 30;
        out_gap_pct = 30;
        for (int r = 0; r < 4; r++) begin
            d0 = done_cnt;
            gen_tile();
            launch(1'b1);
            gen_tile();
            launch(1'b1);
            if (r == 1) begin
                repeat (6) @(negedge clk);
                @(posedge clk); #1 clk_en = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    check("clk_en_ready", {62'd0, bus.coord_in_0_ready, bus.coord_in_1_ready}, 64'd0);
                end
                @(posedge clk); #1 clk_en = 1'b1;
                @(posedge clk); #1 tile_en = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    check("tile_en_ready", {62'd0, bus.coord_in_0_ready, bus.coord_in_1_ready}, 64'd0);
                    check("tile_en_valid", 64'(bus.coord_out_valid | bus.pos_out_0_valid
                                               | bus.pos_out_1_valid), 64'd0);
                end
                @(posedge clk); #1 tile_en = 1'b1;
            end
            wait_drain("random", 3000);
            check("done_twice", 64'(done_cnt - d0), 64'd2);
        end
        in_gap_pct = 0;
        out_gap_pct = 0;

        // Mismatched tokens: error flagged, then the done pair still emits.
        check("proto_err_clear", 64'(proto_err), 64'd0);
        add(0, stop_tok(0), stop_tok(0)); add(0, DONE, DONE);
        add(1, stop_tok(1), stop_tok(1)); add(1, DONE, DONE);
        exp_q.push_back({DONE, DONE, DONE});
        launch(1'b0);
        wait_drain("proto", 200);
        check("proto_err_set", 64'(proto_err), 64'd1);
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check("flush_proto_err", 64'(proto_err), 64'd0);
        check("flush_valid", 64'(bus.coord_out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
